// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared FSM states, stage indices and NOP encoding for the pipeline control block.
package pipeline_ctrl_pkg;
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;
    localparam int STG_IF = 0;
    localparam int STG_ID = 1;
    localparam int STG_EX = 2;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// pipeline_ctrl_hazard_detect: load-use compare between the instruction in EX and the one in ID.
//   i_ex_mem_read, i_ex_rd         : load in EX and its destination register
//   i_id_rs, i_id_rt, i_id_uses_rt : source registers of the instruction in ID
//   o_hazard                       : ID needs the loaded value before it exists
module pipeline_ctrl_hazard_detect #(
    parameter int NB_REG_ADDR = 5
) (
    input  logic                   i_ex_mem_read,
    input  logic [NB_REG_ADDR-1:0] i_ex_rd,
    input  logic [NB_REG_ADDR-1:0] i_id_rs,
    input  logic [NB_REG_ADDR-1:0] i_id_rt,
    input  logic                   i_id_uses_rt,
    output logic                   o_hazard
);
    // $zero is never a real dependency
    assign o_hazard = i_ex_mem_read && (i_ex_rd != '0) &&
                      ((i_ex_rd == i_id_rs) || (i_id_uses_rt && (i_ex_rd == i_id_rt)));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: run/step/halt sequencing, load-use stalls and per-stage enable/flush for the pipeline.
//   i_clock, i_reset (sync, active-high), i_valid (global enable)
//   i_run, i_step                  : start free-running / single-step execution
//   i_halt_instr, i_branch_taken   : control events resolved in ID
//   i_id_*, i_ex_*                 : register operands used for load-use detection
//   o_stage_en, o_stage_flush      : per-stage latch enable and bubble insert
//   o_stall, o_state, o_n_clocks, o_done : status and debug
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int N_STAGES    = 5,
    parameter int NB_REG_ADDR = 5,
    parameter int NB_CNT      = 32
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_valid,
    input  logic                   i_run,
    input  logic                   i_step,
    input  logic                   i_halt_instr,
    input  logic                   i_branch_taken,
    input  logic [NB_REG_ADDR-1:0] i_id_rs,
    input  logic [NB_REG_ADDR-1:0] i_id_rt,
    input  logic                   i_id_uses_rt,
    input  logic [NB_REG_ADDR-1:0] i_ex_rd,
    input  logic                   i_ex_mem_read,
    output logic [N_STAGES-1:0]    o_stage_en,
    output logic [N_STAGES-1:0]    o_stage_flush,
    output logic                   o_stall,
    output logic [2:0]             o_state,
    output logic [NB_CNT-1:0]      o_n_clocks,
    output logic                   o_done
);
    localparam int NB_DRAIN = $clog2(N_STAGES);
    localparam logic [N_STAGES-1:0] ALL = {N_STAGES{1'b1}};

    state_e              state_q, state_d;
    logic                stepmode_q, stepmode_d;
    logic [NB_DRAIN-1:0] drain_q, drain_d;
    logic [NB_CNT-1:0]   cnt_q, cnt_d;
    logic                hazard, adv, stall;

    pipeline_ctrl_hazard_detect #(.NB_REG_ADDR(NB_REG_ADDR)) u_hazard (
        .i_ex_mem_read (i_ex_mem_read),
        .i_ex_rd       (i_ex_rd),
        .i_id_rs       (i_id_rs),
        .i_id_rt       (i_id_rt),
        .i_id_uses_rt  (i_id_uses_rt),
        .o_hazard      (hazard)
    );

    // in step mode each drain beat waits for its own step pulse
    assign adv = i_valid && ((state_q == ST_RUN) || (state_q == ST_STEP) ||
                             ((state_q == ST_DRAIN) && (!stepmode_q || i_step)));
    // hazards are meaningless while draining: fetch is already frozen
    assign stall = adv && hazard && (state_q != ST_DRAIN);

    always_comb begin
        o_stage_en    = '0;
        o_stage_flush = '0;
        if (adv && state_q == ST_DRAIN) begin
            o_stage_en            = ALL & ~(N_STAGES'(1) << STG_IF);
            o_stage_flush[STG_ID] = 1'b1;
        end else if (stall) begin
            // hold IF/ID, let EX onward move on with a bubble behind the load
            o_stage_en            = ALL & ~(N_STAGES'(1) << STG_IF) & ~(N_STAGES'(1) << STG_ID);
            o_stage_flush[STG_EX] = 1'b1;
        end else if (adv) begin
            o_stage_en            = ALL;
            o_stage_flush[STG_ID] = i_branch_taken;
        end
    end

    always_comb begin
        state_d    = state_q;
        stepmode_d = stepmode_q;
        drain_d    = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid && i_run) begin
                    state_d    = ST_RUN;
                    stepmode_d = 1'b0;
                end else if (i_valid && i_step) begin
                    state_d    = ST_STEP;
                    stepmode_d = 1'b1;
                end
            end
            ST_RUN, ST_STEP: begin
                if (adv && i_halt_instr && !stall) begin
                    state_d = ST_DRAIN;
                    drain_d = NB_DRAIN'(N_STAGES - 2);
                end else if (adv && state_q == ST_STEP) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (adv) begin
                    drain_d = drain_q - NB_DRAIN'(1);
                    state_d = (drain_q == NB_DRAIN'(1)) ? ST_DONE : ST_DRAIN;
                end
            end
            default: ;
        endcase
    end

    assign cnt_d = (adv && cnt_q != '1) ? cnt_q + NB_CNT'(1) : cnt_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            stepmode_q <= 1'b0;
            drain_q    <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            stepmode_q <= stepmode_d;
            drain_q    <= drain_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_stall    = stall;
    assign o_state    = state_q;
    assign o_n_clocks = cnt_q;
    assign o_done     = (state_q == ST_DONE);
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed checks of run, stall, branch, halt/drain, step, reset and counter saturation.
module tb_pipeline_ctrl;
    logic       clk = 1'b0;
    logic       rst, valid, run, step, halt, br, uses_rt, mem_rd;
    logic [4:0] rs, rt, ex_rd;
    logic [4:0] en, fl;
    logic       stall, done;
    logic [2:0] state;
    logic [31:0] ncl;
    logic       s_rst, s_run;
    logic [4:0] s_en, s_fl;
    logic       s_stall, s_done;
    logic [2:0] s_state;
    logic [3:0] s_ncl;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.N_STAGES(5), .NB_REG_ADDR(5), .NB_CNT(32)) dut (
        .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_run(run), .i_step(step),
        .i_halt_instr(halt), .i_branch_taken(br), .i_id_rs(rs), .i_id_rt(rt),
        .i_id_uses_rt(uses_rt), .i_ex_rd(ex_rd), .i_ex_mem_read(mem_rd),
        .o_stage_en(en), .o_stage_flush(fl), .o_stall(stall), .o_state(state),
        .o_n_clocks(ncl), .o_done(done)
    );

    pipeline_ctrl #(.N_STAGES(5), .NB_REG_ADDR(5), .NB_CNT(4)) u_sat (
        .i_clock(clk), .i_reset(s_rst), .i_valid(1'b1), .i_run(s_run), .i_step(1'b0),
        .i_halt_instr(1'b0), .i_branch_taken(1'b0), .i_id_rs(5'd0), .i_id_rt(5'd0),
        .i_id_uses_rt(1'b0), .i_ex_rd(5'd0), .i_ex_mem_read(1'b0),
        .o_stage_en(s_en), .o_stage_flush(s_fl), .o_stall(s_stall), .o_state(s_state),
        .o_n_clocks(s_ncl), .o_done(s_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // advance one edge, then settle 1 time unit past it before driving/sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; valid = 0; run = 0; step = 0; halt = 0; br = 0;
        uses_rt = 0; mem_rd = 0; rs = 0; rt = 0; ex_rd = 0;
        s_rst = 1; s_run = 0;
        tick(); tick();
        rst = 0; s_rst = 0;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_en", 32'(en), 32'd0);
        check("rst_flush", 32'(fl), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ncl", ncl, 32'd0);

        valid = 1; run = 1; s_run = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("run_en", 32'(en), 32'h1f);
        end
        check("run_state", 32'(state), 32'd1);
        tick();
        check("run_ncl10", ncl, 32'd10);

        mem_rd = 1; ex_rd = 5'd8; rs = 5'd8; #1;
        check("lu_stall", 32'(stall), 32'd1);
        check("lu_en", 32'(en), 32'h1c);
        check("lu_flush", 32'(fl), 32'h04);
        ex_rd = 5'd0; rs = 5'd0; #1;
        check("r0_stall", 32'(stall), 32'd0);
        check("r0_en", 32'(en), 32'h1f);
        ex_rd = 5'd8; rs = 5'd3; rt = 5'd8; uses_rt = 1; #1;
        check("rt_stall", 32'(stall), 32'd1);
        uses_rt = 0; #1;
        check("rt_unused_stall", 32'(stall), 32'd0);

        rs = 5'd8; br = 1; #1;
        check("stbr_flush", 32'(fl), 32'h04);
        check("stbr_en", 32'(en), 32'h1c);
        tick();
        mem_rd = 0; #1;
        check("br_flush", 32'(fl), 32'h02);
        check("br_en", 32'(en), 32'h1f);
        tick();
        br = 0; halt = 1; #1;
        check("halt_en", 32'(en), 32'h1f);
        tick();
        halt = 0; mem_rd = 1; br = 1; #1;
        check("drain_stall_ign", 32'(stall), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("drain_state", 32'(state), 32'd3);
            check("drain_en", 32'(en), 32'h1e);
            check("drain_flush", 32'(fl), 32'h02);
            tick();
        end
        mem_rd = 0; br = 0; #1;
        check("done_state", 32'(state), 32'd4);
        check("done_flag", 32'(done), 32'd1);
        check("done_en", 32'(en), 32'd0);
        check("done_ncl", ncl, 32'd16);
        tick(); tick(); tick();
        check("done_ncl_frozen", ncl, 32'd16);
        check("done_hold", 32'(state), 32'd4);

        rst = 1; run = 0; tick(); rst = 0; #1;
        check("step_rst_ncl", ncl, 32'd0);
        for (int p = 0; p < 3; p++) begin
            step = 1; #1;
            check("step_idle_en", 32'(en), 32'd0);
            tick();
            step = 0; #1;
            check("step_state", 32'(state), 32'd2);
            check("step_en", 32'(en), 32'h1f);
            tick();
            check("step_back_idle", 32'(state), 32'd0);
            check("step_idle_en2", 32'(en), 32'd0);
            tick(); tick();
        end
        check("step_ncl3", ncl, 32'd3);

        rst = 1; tick(); rst = 0;
        run = 1; tick(); run = 0;
        valid = 0; #1;
        check("nv_en", 32'(en), 32'd0);
        tick();
        check("nv_state", 32'(state), 32'd1);
        check("nv_ncl", ncl, 32'd0);
        valid = 1; halt = 1; tick(); halt = 0;
        tick();
        check("drain2_state", 32'(state), 32'd3);
        check("drain2_ncl", ncl, 32'd2);
        rst = 1; tick(); rst = 0; #1;
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_ncl", ncl, 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_en", 32'(en), 32'd0);

        check("sat_ncl", 32'(s_ncl), 32'd15);
        check("sat_state", 32'(s_state), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
